// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: immediate-extension mode encodings.
package mips_pkg;
  localparam int IMM_MODE_W = 2;

  localparam logic [IMM_MODE_W-1:0] IMM_SIGN   = 2'b00;
  localparam logic [IMM_MODE_W-1:0] IMM_ZERO   = 2'b01;
  localparam logic [IMM_MODE_W-1:0] IMM_UPPER  = 2'b10;
  localparam logic [IMM_MODE_W-1:0] IMM_BRANCH = 2'b11;
endpackage

// File: rtl/imm_ext_skid.sv
// One-entry valid/ready skid register; in_ready is registered so upstream
// never sees a combinational path from the downstream ready.
module imm_ext_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         skid_valid_d, skid_valid_q;
  logic [W-1:0] skid_data_d,  skid_data_q;

  // Empty skid is a pass-through; it only captures when downstream stalls.
  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (out_ready) skid_valid_d = 1'b0;
    end else if (in_valid && !out_ready) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) skid_valid_q <= 1'b0;
    else     skid_valid_q <= skid_valid_d;
  end

  always_ff @(posedge clk) begin
    skid_data_q <= skid_data_d;
  end

  assign in_ready  = ~skid_valid_q;
  assign out_valid = skid_valid_q | in_valid;
  assign out_data  = skid_valid_q ? skid_data_q : in_data;
endmodule

// File: rtl/imm_ext_pipe.sv
// Two-stage valid/ready immediate extender (sign/zero/upper/branch modes).
// Define IMM_EXT_SKID_EN to add a one-entry input skid with registered in_ready.
module imm_ext_pipe
  import mips_pkg::*;
#(
  parameter int IN_SIZE  = 16,
  parameter int OUT_SIZE = 32,
  parameter int TAG_W    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IMM_MODE_W-1:0] in_mode,
  input  logic [IN_SIZE-1:0]    in_data,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_SIZE-1:0]   out_data,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_neg,
  output logic                  busy
);
  localparam int E  = OUT_SIZE - IN_SIZE;
  localparam int PW = IMM_MODE_W + IN_SIZE + TAG_W;

  if (OUT_SIZE <= IN_SIZE || IN_SIZE < 2) begin : g_param_chk
    $error("imm_ext_pipe: need IN_SIZE >= 2 and OUT_SIZE > IN_SIZE");
  end

  function automatic logic [OUT_SIZE-1:0] imm_extend(
    input logic [IMM_MODE_W-1:0] mode,
    input logic [IN_SIZE-1:0]    imm
  );
    logic signed [OUT_SIZE-1:0] sext;
    logic        [OUT_SIZE-1:0] zext;
    sext = {{E{imm[IN_SIZE-1]}}, imm};
    zext = {{E{1'b0}}, imm};
    case (mode)
      IMM_SIGN:  imm_extend = sext;
      IMM_ZERO:  imm_extend = zext;
      // LUI-style: shifting by IN_SIZE drops the top of imm when E < IN_SIZE.
      IMM_UPPER: imm_extend = zext << IN_SIZE;
      default:   imm_extend = sext <<< 2;
    endcase
  endfunction

  logic                  s1_adv, s2_adv;
  logic                  s1_in_valid;
  logic [PW-1:0]         s1_in_pkt;
  logic                  skid_busy;

  logic                  vld_p1_d, vld_p1_q;
  logic [PW-1:0]         pkt_p1_d, pkt_p1_q;
  logic                  vld_p2_d, vld_p2_q;
  logic [OUT_SIZE-1:0]   data_p2_d, data_p2_q;
  logic [TAG_W-1:0]      tag_p2_d, tag_p2_q;

  assign s2_adv = ~vld_p2_q | out_ready;
  assign s1_adv = ~vld_p1_q | s2_adv;

  // ---- input boundary: optional skid in front of stage 1 ----
`ifdef IMM_EXT_SKID_EN
  logic skid_in_ready;

  imm_ext_skid #(.W(PW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid & in_ready),
    .in_ready  (skid_in_ready),
    .in_data   ({in_mode, in_data, in_tag}),
    .out_valid (s1_in_valid),
    .out_ready (s1_adv),
    .out_data  (s1_in_pkt)
  );

  assign in_ready  = skid_in_ready & ~flush & ~rst;
  assign skid_busy = ~skid_in_ready;
`else
  assign in_ready    = s1_adv & ~flush & ~rst;
  assign s1_in_valid = in_valid & in_ready;
  assign s1_in_pkt   = {in_mode, in_data, in_tag};
  assign skid_busy   = 1'b0;
`endif

  always_comb begin
    vld_p1_d  = vld_p1_q;
    pkt_p1_d  = pkt_p1_q;
    vld_p2_d  = vld_p2_q;
    data_p2_d = data_p2_q;
    tag_p2_d  = tag_p2_q;
    if (flush) begin
      vld_p1_d = 1'b0;
      vld_p2_d = 1'b0;
    end else begin
      if (s1_adv) vld_p1_d = s1_in_valid;
      if (s2_adv) vld_p2_d = vld_p1_q;
    end
    // ---- stage 1 -> stage 2: extension computed from registered operands ----
    if (s1_adv && s1_in_valid) pkt_p1_d = s1_in_pkt;
    if (s2_adv && vld_p1_q) begin
      data_p2_d = imm_extend(pkt_p1_q[PW-1 -: IMM_MODE_W], pkt_p1_q[TAG_W +: IN_SIZE]);
      tag_p2_d  = pkt_p1_q[TAG_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      data_p2_q <= '0;
      tag_p2_q  <= '0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      data_p2_q <= data_p2_d;
      tag_p2_q  <= tag_p2_d;
    end
  end

  always_ff @(posedge clk) begin
    pkt_p1_q <= pkt_p1_d;
  end

  // ---- stage 2: output ----
  assign out_valid = vld_p2_q;
  assign out_data  = data_p2_q;
  assign out_tag   = tag_p2_q;
  assign out_neg   = data_p2_q[OUT_SIZE-1];
  assign busy      = vld_p1_q | vld_p2_q | skid_busy;
endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe (default 16->32 instance plus an 8->12 instance).
module tb_imm_ext_pipe;
`ifdef IMM_EXT_SKID_EN
  localparam int CAP = 3;
`else
  localparam int CAP = 2;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_neg, busy;
  logic [1:0]  in_mode;
  logic [15:0] in_data;
  logic [4:0]  in_tag, out_tag;
  logic [31:0] out_data;

  logic        v8, r8, ov8, on8, b8;
  logic [1:0]  m8;
  logic [7:0]  d8;
  logic [2:0]  t8, ot8;
  logic [11:0] od8;

  always #5 clk = ~clk;

  imm_ext_pipe u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .out_neg(out_neg), .busy(busy)
  );

  imm_ext_pipe #(.IN_SIZE(8), .OUT_SIZE(12), .TAG_W(3)) u_dut8 (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(v8), .in_ready(r8), .in_mode(m8), .in_data(d8), .in_tag(t8),
    .out_valid(ov8), .out_ready(1'b1), .out_data(od8), .out_tag(ot8),
    .out_neg(on8), .busy(b8)
  );

  typedef struct {
    logic [31:0] d;
    logic [4:0]  t;
    int          c;
  } ent_t;

  ent_t        sb[$];
  int          n_cmp = 0, n_err = 0, cycle = 0, acc_cnt = 0;
  bit          lat_chk = 0;
  logic [31:0] nexp, held;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  function automatic logic [31:0] ref_ext(input logic [1:0] m, input logic [15:0] d);
    int s;
    s = d[15] ? int'(d) - 65536 : int'(d);
    case (m)
      2'd0:    return 32'(s);
      2'd1:    return 32'(d);
      2'd2:    return 32'(d) * 32'h0001_0000;
      default: return 32'(s * 4);
    endcase
  endfunction

  task automatic drive(input logic v, input logic [1:0] m, input logic [15:0] d, input logic [4:0] t);
    in_valid = v; in_mode = m; in_data = d; in_tag = t;
    nexp = ref_ext(m, d);
  endtask

  // One clock: score the output transfer and the input transfer, then advance.
  task automatic cyc();
    ent_t e;
    #1;
    if (out_valid && out_ready) begin
      chk("sb_has_entry", 64'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("data", out_data, e.d);
        chk("tag", out_tag, e.t);
        chk("neg", out_neg, e.d[31]);
        if (lat_chk) chk("latency", 64'(cycle - e.c), 2);
      end
    end
    if (in_valid && in_ready) begin
      acc_cnt++;
      sb.push_back('{nexp, in_tag, cycle});
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic send_k(input logic [1:0] m, input logic [15:0] d, input logic [4:0] t, input logic [31:0] k);
    drive(1'b1, m, d, t);
    nexp = k;
    cyc();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (sb.size() != 0 || busy); i++) cyc();
    chk("drain_sb_empty", 64'(sb.size()), 0);
    chk("drain_busy", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 2'd0, 16'h0, 5'd0);
    v8 = 1'b0; m8 = 2'd0; d8 = 8'h0; t8 = 3'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_neg", out_neg, 0);
    chk("rst_busy", busy, 0);
    #2 rst = 1'b0;
    #1 chk("rel_in_ready", in_ready, 1);

    // Modes with fixed expectations, latency 2
    lat_chk = 1;
    send_k(2'd0, 16'h8304, 5'd1, 32'hFFFF_8304);
    send_k(2'd1, 16'h8304, 5'd2, 32'h0000_8304);
    send_k(2'd2, 16'h3304, 5'd3, 32'h3304_0000);
    send_k(2'd3, 16'hFFFF, 5'd4, 32'hFFFF_FFFC);
    send_k(2'd3, 16'h7FFF, 5'd5, 32'h0001_FFFC);
    drain();

    // Streaming, tags 0..7
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'(i), 16'($urandom) | (i[0] ? 16'h8000 : 16'h0), 5'(i));
      cyc();
    end
    drain();
    lat_chk = 0;

    // Backpressure
    acc_cnt   = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 2'($urandom_range(0, 3)), 16'($urandom), 5'(10 + i));
      cyc();
      if (i == 2) held = out_data;
      else if (i > 2) chk("bp_hold", out_data, held);
    end
    chk("bp_accepted", 64'(acc_cnt), 64'(CAP));
    drain();

    // Flush with a full pipe
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'd0, 16'h9000 + 16'(i), 5'(20 + i));
      cyc();
    end
    chk("fl_busy_before", busy, 1);
    flush = 1'b1;
    drive(1'b1, 2'd1, 16'hABCD, 5'd30);
    #1 chk("fl_in_ready", in_ready, 0);
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_busy", busy, 0);
    sb.delete();
    out_ready = 1'b1;
    repeat (3) cyc();
    drive(1'b1, 2'd3, 16'h1234, 5'd9);
    cyc();
    drain();

    // Asynchronous reset mid-stream
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'd0, 16'h8001 + 16'(i), 5'(i + 1));
      cyc();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_tag", out_tag, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_busy", busy, 0);
    sb.delete();
    @(posedge clk);
    #1 chk("arst_in_ready_hold", in_ready, 0);
    #2 rst = 1'b0;
    #1 chk("arst_rel_in_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("arst_no_out", out_valid, 0);
    end

    // Narrow instance: 8 -> 12
    v8 = 1'b1; m8 = 2'd0; d8 = 8'h80; t8 = 3'd1;
    #1 chk("p8_ready", r8, 1);
    @(posedge clk);
    #1;
    m8 = 2'd2; d8 = 8'hA5; t8 = 3'd2;
    @(posedge clk);
    #1;
    v8 = 1'b0;
    chk("p8_valid_a", ov8, 1);
    chk("p8_sign", od8, 12'hF80);
    chk("p8_tag_a", ot8, 1);
    chk("p8_neg", on8, 1);
    @(posedge clk);
    #1;
    chk("p8_valid_b", ov8, 1);
    chk("p8_upper", od8, 12'h500);
    chk("p8_tag_b", ot8, 2);
    @(posedge clk);
    #1 chk("p8_idle", ov8, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
